// File: rtl/conv1d_2nd_read_scheduler_if.sv
// Handshake and RAM-read bundle between the conv1d layer-2 read scheduler and its controller.
// The controller drives start/stall/write_busy; the scheduler drives the rest.
interface conv1d_2nd_read_scheduler_if #(
  parameter int unsigned FILT_W = 4
);
  logic              start;
  logic              write_busy;
  logic              stall;
  logic              busy;
  logic              done;
  logic              read_enable;
  logic [2:0]        read_depth;
  logic [7:0]        read_width;
  logic              data_valid;
  logic              acc_clear;
  logic              acc_dump;
  logic [7:0]        out_width;
  logic [FILT_W-1:0] filter_index;

  modport master (
    output start, write_busy, stall,
    input  busy, done, read_enable, read_depth, read_width,
    input  data_valid, acc_clear, acc_dump, out_width, filter_index
  );

  modport slave (
    input  start, write_busy, stall,
    output busy, done, read_enable, read_depth, read_width,
    output data_valid, acc_clear, acc_dump, out_width, filter_index
  );
endinterface

// File: rtl/conv1d_2nd_read_scheduler.sv
// Read-side sequencer for the layer-2 CONV1D data RAM: walks filter/width/channel and emits
// RAM reads plus the one-cycle-delayed valid/clear/dump/tag stream for the MAC.
module conv1d_2nd_read_scheduler #(
  parameter int unsigned IN_CH  = 8,
  parameter int unsigned WIDTH  = 256,
  parameter int unsigned OUT_CH = 16,
  parameter int unsigned FILT_W = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  conv1d_2nd_read_scheduler_if.slave bus_io
);

  localparam logic [2:0]        DLast = 3'(IN_CH - 1);
  localparam logic [7:0]        WLast = 8'(WIDTH - 1);
  localparam logic [FILT_W-1:0] FLast = FILT_W'(OUT_CH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        d_q, d_d;
  logic [7:0]        w_q, w_d;
  logic [FILT_W-1:0] f_q, f_d;
  logic              issue;
  logic              busy_d;

  logic              re_q;
  logic [2:0]        rd_depth_q;
  logic [7:0]        rd_width_q;
  logic [FILT_W-1:0] rd_f_q;
  logic              dv_q, clr_q, dump_q, busy_q, done_q;
  logic [7:0]        ow_q;
  logic [FILT_W-1:0] fi_q;

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    w_d     = w_q;
    f_d     = f_q;
    issue   = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus_io.start && !bus_io.write_busy) begin
          issue   = 1'b1;
          state_d = StRun;
        end
      end
      StRun:   issue   = !bus_io.stall;
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // Counters sit at the next read to issue; the first read comes straight from IDLE.
    if (issue) begin
      if (d_q == DLast) begin
        d_d = '0;
        if (w_q == WLast) begin
          w_d = '0;
          if (f_q == FLast) begin
            f_d     = '0;
            state_d = StDrain;
          end else begin
            f_d = f_q + 1'b1;
          end
        end else begin
          w_d = w_q + 8'd1;
        end
      end else begin
        d_d = d_q + 3'd1;
      end
    end
    busy_d = (state_q != StIdle) || (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      d_q        <= '0;
      w_q        <= '0;
      f_q        <= '0;
      re_q       <= 1'b0;
      rd_depth_q <= '0;
      rd_width_q <= '0;
      rd_f_q     <= '0;
      dv_q       <= 1'b0;
      clr_q      <= 1'b0;
      dump_q     <= 1'b0;
      ow_q       <= '0;
      fi_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      w_q        <= w_d;
      f_q        <= f_d;
      re_q       <= issue;
      rd_depth_q <= issue ? d_q : '0;
      rd_width_q <= issue ? w_q : '0;
      rd_f_q     <= issue ? f_q : '0;
      // RAM samples on the negedge of the read cycle, so its data is usable one cycle later.
      dv_q       <= re_q;
      clr_q      <= re_q && (rd_depth_q == '0);
      dump_q     <= re_q && (rd_depth_q == DLast);
      ow_q       <= rd_width_q;
      fi_q       <= rd_f_q;
      busy_q     <= busy_d;
      done_q     <= (state_q == StDone);
    end
  end

  assign bus_io.read_enable  = re_q;
  assign bus_io.read_depth   = rd_depth_q;
  assign bus_io.read_width   = rd_width_q;
  assign bus_io.data_valid   = dv_q;
  assign bus_io.acc_clear    = clr_q;
  assign bus_io.acc_dump     = dump_q;
  assign bus_io.out_width    = ow_q;
  assign bus_io.filter_index = fi_q;
  assign bus_io.busy         = busy_q;
  assign bus_io.done         = done_q;

endmodule

// File: tb/tb_conv1d_2nd_read_scheduler.sv
// Directed bench: a small 2x3x2 scheduler for sequencing/stall/interlock/abort cases and a
// default-size one for the full walk under random stall.
module tb_conv1d_2nd_read_scheduler;

  localparam int SIN = 2;
  localparam int SW  = 3;
  localparam int SF  = 2;
  localparam int SN  = SIN * SW * SF;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  conv1d_2nd_read_scheduler_if #(.FILT_W(4)) s_if ();
  conv1d_2nd_read_scheduler_if #(.FILT_W(4)) d_if ();

  conv1d_2nd_read_scheduler #(.IN_CH(SIN), .WIDTH(SW), .OUT_CH(SF), .FILT_W(4)) u_small (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (s_if)
  );

  conv1d_2nd_read_scheduler #(.IN_CH(8), .WIDTH(256), .OUT_CH(16), .FILT_W(4)) u_dflt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (d_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] s_outs();
    return 32'({s_if.busy, s_if.done, s_if.read_enable, s_if.read_depth, s_if.read_width,
                s_if.data_valid, s_if.acc_clear, s_if.acc_dump, s_if.out_width,
                s_if.filter_index});
  endfunction

  function automatic logic [31:0] d_outs();
    return 32'({d_if.busy, d_if.done, d_if.read_enable, d_if.read_depth, d_if.read_width,
                d_if.data_valid, d_if.acc_clear, d_if.acc_dump, d_if.out_width,
                d_if.filter_index});
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One run of the small DUT; optional stall after read #stall_at and a start+write_busy poke.
  task automatic run_small(input int stall_at, input int stall_len, input int poke_at);
    int rdn = 0, dvn = 0, left = 0, done_n = 0, done_cyc = -1, busy_n = 0;
    s_if.start = 1'b1;
    tick();
    s_if.start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (left > 0) begin
        left--;
        if (left == 0) s_if.stall = 1'b0;
      end
      s_if.start = (cyc == poke_at);
      if (cyc == poke_at) s_if.write_busy = 1'b1;
      if (s_if.read_enable) begin
        chk("rd_depth", 32'(s_if.read_depth), 32'(rdn % SIN));
        chk("rd_width", 32'(s_if.read_width), 32'((rdn / SIN) % SW));
        rdn++;
        if (rdn == stall_at && stall_len > 0) begin
          s_if.stall = 1'b1;
          left       = stall_len;
        end
      end
      if (s_if.data_valid) begin
        chk("out_width", 32'(s_if.out_width), 32'((dvn / SIN) % SW));
        chk("filter_index", 32'(s_if.filter_index), 32'(dvn / (SIN * SW)));
        chk("acc_clear", 32'(s_if.acc_clear), 32'(dvn % SIN == 0));
        chk("acc_dump", 32'(s_if.acc_dump), 32'(dvn % SIN == SIN - 1));
        dvn++;
      end
      if (s_if.busy) busy_n++;
      if (s_if.done) begin
        done_n++;
        done_cyc = cyc;
      end
      tick();
    end
    s_if.write_busy = 1'b0;
    chk("read_count", 32'(rdn), 32'(SN));
    chk("valid_count", 32'(dvn), 32'(SN));
    chk("done_count", 32'(done_n), 32'd1);
    chk("done_cycle", 32'(done_cyc), 32'(SN + 2 + stall_len));
    chk("busy_cycles", 32'(busy_n), 32'(SN + 2 + stall_len));
    chk("idle_outputs", s_outs(), 32'd0);
  endtask

  initial begin
    int rdn, dvn, done_n, maxw, idx;
    logic [7:0] dmask;
    rst_n = 1'b0;
    s_if.start = 1'b0; s_if.write_busy = 1'b0; s_if.stall = 1'b0;
    d_if.start = 1'b0; d_if.write_busy = 1'b0; d_if.stall = 1'b0;
    tick();
    tick();
    chk("reset_small", s_outs(), 32'd0);
    chk("reset_dflt", d_outs(), 32'd0);
    rst_n = 1'b1;
    tick();

    // Plain run, then the 3-cycle stall after the 5th read.
    run_small(0, 0, 0);
    run_small(5, 3, 0);

    // Start blocked by write_busy, then accepted once it drops.
    s_if.write_busy = 1'b1;
    s_if.start      = 1'b1;
    tick();
    s_if.start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("wb_block_busy", 32'(s_if.busy), 32'd0);
      chk("wb_block_re", 32'(s_if.read_enable), 32'd0);
      tick();
    end
    s_if.write_busy = 1'b0;
    run_small(0, 0, 0);

    // Second start (with write_busy raised) mid-run is ignored.
    run_small(0, 0, 4);

    // Asynchronous abort after the 7th read.
    s_if.start = 1'b1;
    tick();
    s_if.start = 1'b0;
    rdn = 0;
    for (int c = 0; c < 20 && rdn < 7; c++) begin
      if (s_if.read_enable) rdn++;
      if (rdn < 7) tick();
    end
    chk("abort_reached", 32'(rdn), 32'd7);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", s_outs(), 32'd0);
    tick();
    tick();
    rst_n  = 1'b1;
    done_n = 0;
    for (int c = 0; c < 20; c++) begin
      if (s_if.done || s_if.read_enable) done_n++;
      tick();
    end
    chk("abort_quiet", 32'(done_n), 32'd0);
    run_small(0, 0, 0);

    // Full default-size walk under random stall.
    d_if.start = 1'b1;
    tick();
    d_if.start = 1'b0;
    rdn = 0; dvn = 0; done_n = 0; maxw = 0; dmask = '0;
    for (int c = 0; c < 60000 && done_n == 0; c++) begin
      if (d_if.read_enable) begin
        idx = ((rdn % 8) << 8) | ((rdn / 8) % 256);
        chk("dflt_read", 32'({d_if.read_depth, d_if.read_width}), 32'(idx));
        if (int'(d_if.read_width) > maxw) maxw = int'(d_if.read_width);
        dmask[d_if.read_depth] = 1'b1;
        rdn++;
      end
      if (d_if.data_valid) begin
        idx = ((dvn / 2048) << 10) | (((dvn / 8) % 256) << 2) | (((dvn % 8) == 0) ? 2 : 0)
            | (((dvn % 8) == 7) ? 1 : 0);
        chk("dflt_tags", 32'({d_if.filter_index, d_if.out_width, d_if.acc_clear, d_if.acc_dump}),
            32'(idx));
        dvn++;
      end
      if (d_if.done) done_n++;
      d_if.stall = ($urandom_range(0, 3) == 0);
      tick();
    end
    d_if.stall = 1'b0;
    chk("dflt_reads", 32'(rdn), 32'd32768);
    chk("dflt_valids", 32'(dvn), 32'd32768);
    chk("dflt_done", 32'(done_n), 32'd1);
    chk("dflt_max_width", 32'(maxw), 32'd255);
    chk("dflt_depth_cover", 32'(dmask), 32'hff);
    tick();
    chk("dflt_idle", d_outs(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
